// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative unsigned WIDTH x WIDTH multiplier that
// adds one partial product per clock through its carry_look_ahead instance.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset; aborts any operation in flight
//   start  in   request; accepted only on a rising edge where ready=1
//   a, b   in   multiplicand / multiplier, sampled on the accept edge only
//   ready  out  high in IDLE
//   busy   out  high in RUN
//   done   out  one-cycle pulse, high in DONE
//   p      out  2*WIDTH-bit product register, updated only on entry to DONE
//
// Handshake: a request is accepted on the edge where start=1 and ready=1;
// nothing is queued, so start seen in RUN or DONE is dropped. After WIDTH
// add/shift iterations (fewer with early exit) done pulses for one cycle
// and p carries the product until the next completion.
//
// Build option: define MULT_EARLY_EXIT_EN to finish as soon as the multiplier
// bits still to be consumed are all zero; the result is aligned with a small
// barrel shifter. Without it every operation runs exactly WIDTH iterations.

// Carry look-ahead adder: s = a + b + y, carry-out on c. Every carry is
// computed directly from generate/propagate terms rather than rippled.
module carry_look_ahead #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             y,
  output logic [WIDTH-1:0] s,
  output logic             c
);
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // carry[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]y
  always_comb begin
    logic acc;
    logic run;
    carry    = '0;
    acc      = 1'b0;
    run      = 1'b0;
    carry[0] = y;
    for (int i = 0; i < WIDTH; i++) begin
      acc = gen[i];
      run = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (run & gen[j]);
        run = run & prop[j];
      end
      acc = acc | (run & y);
      carry[i+1] = acc;
    end
  end

  assign s = prop ^ carry[WIDTH-1:0];
  assign c = carry[WIDTH];
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;   // {hi, lo}
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     hi, lo;
  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_s;
  logic                 add_c;
  logic [2*WIDTH-1:0]   step;
  logic                 last_iter;

  assign hi    = prod_q[2*WIDTH-1:WIDTH];
  assign lo    = prod_q[WIDTH-1:0];
  assign add_b = lo[0] ? mcand_q : '0;

  carry_look_ahead #(.WIDTH(WIDTH)) u_cla (
    .a (hi),
    .b (add_b),
    .y (1'b0),
    .s (add_s),
    .c (add_c)
  );

  // {c, s, lo} >> 1: the carry-out becomes the new top bit and the consumed
  // multiplier bit falls off the bottom.
  assign step      = {add_c, add_s, lo[WIDTH-1:1]};
  assign last_iter = (count_q == CW'(WIDTH - 1));

`ifdef MULT_EARLY_EXIT_EN
  logic [WIDTH-1:0]   live_mask;
  logic               lo_rem_zero;
  logic [CW-1:0]      exit_shift;
  logic [2*WIDTH-1:0] exit_p;

  // lo[WIDTH-1-count:0] are the multiplier bits not yet consumed; the upper
  // count bits of lo already hold low product bits.
  assign live_mask   = {WIDTH{1'b1}} >> count_q;
  assign lo_rem_zero = ((lo & live_mask) == '0);
  assign exit_shift  = CW'(WIDTH) - count_q;
  assign exit_p      = prod_q >> exit_shift;
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    count_d = count_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a;
          prod_d  = {{WIDTH{1'b0}}, b};
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
`ifdef MULT_EARLY_EXIT_EN
        if (lo_rem_zero) begin
          p_d     = exit_p;
          state_d = S_DONE;
        end else begin
          prod_d  = step;
          count_d = count_q + 1'b1;
          if (last_iter) begin
            p_d     = step;
            state_d = S_DONE;
          end
        end
`else
        prod_d  = step;
        count_d = count_q + 1'b1;
        if (last_iter) begin
          p_d     = step;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign p     = p_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier (WIDTH=4). Expected products come from
// a*b; expected run lengths from the operand's most significant set bit.
module tb_shift_add_multiplier;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     a_i, b_i;
  logic             ready, busy, done;
  logic [2*W-1:0]   p;

  int checks = 0;
  int errors = 0;
  int unsigned cycle_cnt = 0;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_p;
  int             last_accept;
  int             last_len;
  bit             have_last;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of RUN cycles an operation with multiplier bv should take.
  function automatic int exp_len(input logic [W-1:0] bv);
`ifdef MULT_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < W; i++) if (bv[i]) msb = i;
    if (msb < 0) return 1;
    return (msb + 2 < W) ? msb + 2 : W;
`else
    return W;
`endif
  endfunction

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p", p, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_p = '0;
    have_last = 0;
  endtask

  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input bit hold, input bit chk_spacing);
    int len, k, acc;
    bit seen;
    logic [2*W-1:0] expv;
    len = exp_len(ob);
    check("ready_before_accept", ready, 1);
    a_i = oa; b_i = ob; start = 1'b1;
    exp_q.push_back((2*W)'(oa) * (2*W)'(ob));
    @(posedge clk);
    #1;
    acc = int'(cycle_cnt);
    if (chk_spacing && have_last) check("accept_spacing", acc - last_accept, last_len + 2);
    have_last = 1; last_accept = acc; last_len = len;
    if (!hold) start = 1'b0;
    k = 0; seen = 0;
    while (!seen && k < 3*W + 10) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        check("busy_in_run", busy, 1);
        check("ready_low_in_run", ready, 0);
        check("p_stable_in_run", p, last_p);
        a_i = W'($urandom); b_i = W'($urandom);
        k++;
      end
    end
    expv = exp_q.pop_front();
    if (!seen) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("run_length", k, len);
    check("product", p, expv);
    last_p = expv;
    a_i = W'($urandom); b_i = W'($urandom);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after_done", ready, 1);
    check("busy_after_done", busy, 0);
    check("p_hold", p, last_p);
  endtask

  initial begin
    do_reset();

    // 15*15 with hold check
    run_op(4'd15, 4'd15, 0, 0);
    repeat (5) @(negedge clk);
    check("p_hold_long", p, 225);

    run_op(4'd13, 4'd11, 0, 0);
    run_op(4'd0,  4'd9,  0, 0);
    run_op(4'd9,  4'd0,  0, 0);

    // early-exit lengths (full length without the macro)
    run_op(4'd5, 4'd0, 0, 0);
    run_op(4'd5, 4'd1, 0, 0);
    run_op(4'd5, 4'd8, 0, 0);

    // start held high: one result per L+2 cycles, DONE-cycle start dropped
    have_last = 0;
    for (int n = 0; n < 10; n++) run_op(W'($urandom), W'($urandom), 1, 1);
    start = 1'b0;
    @(negedge clk);

    // reset after two iterations of an operation
    a_i = 4'd5; b_i = 4'd15; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_p", p, 0);
    start = 1'b1;  // rst must win over start
    @(negedge clk);
    check("rst_wins_busy", busy, 0);
    start = 1'b0;
    rst = 1'b0;
    last_p = '0;
    have_last = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("no_done_after_abort", done, 0);
      check("idle_after_abort", ready, 1);
    end
    run_op(4'd7, 4'd6, 0, 0);
    check("p_after_abort_op", p, 42);

    // exhaustive sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        run_op(W'(ia), W'(ib), 0, 0);

    // random operations
    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
